uart_rx_x8: RTL and testbench

UART receiver that consumes the 8x oversampling clock produced by the baud rate generator.
- Synchronises the serial rxd line, finds start bits, samples each data bit at mid-bit, and checks the stop bit.
- Presents each received byte on a valid/ready interface to the matrix-multiply command/data loader.
- All logic runs in the clk domain. bclk_x8 is treated as a level signal; its rising edges become one-clk tick enables.

---
 rtl/uart_pkg.sv | 56 +++++
 rtl/uart_sync_edge.sv | 55 +++++
 rtl/uart_rx_x8.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_x8.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART blocks: receiver state encoding, the
//   baud select encoding used by the baud rate generator, and the system
//   clock / oversampling constants.
//
//   Contents:
//     CLK_HZ              system clock frequency in Hz
//     DEFAULT_OVERSAMPLE  ticks per bit period of the oversampling clock
//     rx_state_t          receiver FSM states
//     baud_sel_t          2-bit baud select (00=9600 .. 11=115200)
//     baud_rate()         baud rate in bit/s for a select code
//     tick_period()       clk cycles per oversampling tick for a select code
//
//   Optional feature macro used by the receiver: UART_RX_PARITY_EN
//   (the PARITY state value exists in the enum either way).

package uart_pkg;

    localparam int CLK_HZ             = 100_000_000;
    localparam int DEFAULT_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'b00,
        BAUD_19200  = 2'b01,
        BAUD_57600  = 2'b10,
        BAUD_115200 = 2'b11
    } baud_sel_t;

    function automatic int baud_rate(input baud_sel_t sel);
        case (sel)
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_57600:  return 57600;
            BAUD_115200: return 115200;
            default:     return 9600;
        endcase
    endfunction

    // The generator toggles every half period (rounded down), so one full
    // tick is twice the half-period divisor: 108 clk at 115200, 1302 at 9600.
    function automatic int tick_period(input baud_sel_t sel);
        int half;
        half = CLK_HZ / (baud_rate(sel) * DEFAULT_OVERSAMPLE * 2);
        return 2 * half;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge
//   Front end shared by the UART blocks: a SYNC_STAGES-deep synchroniser for
//   the asynchronous serial line and a rising-edge detector that turns the
//   oversampling square wave into single-clk tick enables.
//
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous, active-high reset
//     rxd      in   raw serial line (idle high)
//     bclk_x8  in   oversampling square wave, treated as a level
//     rxd_s    out  synchronised serial line
//     tick     out  one-clk pulse per rising edge of bclk_x8

module uart_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    input  logic bclk_x8,
    output logic rxd_s,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bclk_q;
    logic                   bclk_qq;

    // Synchroniser resets to all ones so a reset release never looks like
    // a falling start edge on an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Two samples of the square wave; a 0->1 transition between them is
    // one tick. A stopped bclk_x8 simply produces no ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_q  <= 1'b0;
            bclk_qq <= 1'b0;
        end else begin
            bclk_q  <= bclk_x8;
            bclk_qq <= bclk_q;
        end
    end

    assign tick = bclk_q & ~bclk_qq;

endmodule

// File: rtl/uart_rx_x8.sv
// uart_rx_x8
//   UART receiver driven by the 8x oversampling clock from the baud rate
//   generator. Finds start bits, samples each bit at mid-bit, checks the
//   stop bit and hands each byte to the consumer on a valid/ready port.
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous, active-high reset
//     bclk_x8      in   oversampling square wave
//     rxd          in   serial input, idle high
//     rx_data      out  received byte, stable while rx_valid is high
//     rx_valid     out  byte available, held until rx_ready is seen
//     rx_ready     in   consumer accepts on rx_valid && rx_ready
//     framing_err  out  one-clk pulse when the stop bit samples low
//     overrun_err  out  one-clk pulse when a byte is dropped because the
//                       previous one was still waiting
//     busy         out  high whenever the FSM is not idle
//     parity_err   out  (UART_RX_PARITY_EN only) one-clk pulse on a parity
//                       mismatch in a frame with a good stop bit
//
//   Build option: define UART_RX_PARITY_EN to add a parity bit between the
//   data and stop bits (PARITY_ODD selects odd parity, default even).

module uart_rx_x8
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk_x8,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 tick;

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .rxd     (rxd),
        .bclk_x8 (bclk_x8),
        .rxd_s   (rxd_s),
        .tick    (tick)
    );

    // Receiver FSM. Everything except the consumer handshake only moves on
    // tick cycles, so a stopped bclk_x8 freezes the frame in place.
    //
    // Sample points: the start bit is confirmed OVERSAMPLE/2 ticks after it
    // was first seen low (mid-bit); every later bit is sampled a full
    // OVERSAMPLE ticks after the previous sample, which keeps all samples
    // near mid-bit. Data shifts in at the MSB so the first (LSB) bit ends
    // up in bit 0.
    //
    // A completed byte is only dropped when the previous byte is still
    // pending and not being accepted on this very edge; the later
    // assignment to rx_valid overrides the handshake clear so a byte that
    // completes on the accepting edge is loaded without loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end

                    START: begin
                        if (cnt == CNT_HALF) begin
                            cnt <= '0;
                            if (!rxd_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            par_bit <= rxd_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`endif

                    STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (rx_valid && !rx_ready) begin
                                    overrun_err <= 1'b1;
                                end else begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                // Even parity: data plus parity bit must hold
                                // an even number of ones; odd parity inverts.
                                if ((^{shreg, par_bit}) != PARITY_ODD) begin
                                    parity_err <= 1'b1;
                                end
`endif
                            end else begin
                                framing_err <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    // Line held low after a bad stop bit: stay here silently
                    // until it returns high, so a long break gives one error.
                    BREAK: begin
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_x8.sv
// tb_uart_rx_x8
//   Self-checking bench for uart_rx_x8. Frames are built bit by bit from
//   the byte value and driven on rxd at a fixed number of clk per bit. A
//   transaction-level model predicts, per frame, which byte must appear on
//   the valid/ready port and which error pulses must occur; a monitor on
//   the falling clock edge checks every cycle against that prediction.
//   Builds with or without UART_RX_PARITY_EN.

module tb_uart_rx_x8;
    import uart_pkg::*;

    localparam int OS        = 8;
    localparam int DB        = 8;
    localparam int FREEZE_CLK = 60;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ODD   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       bclk_x8;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // Oversampling clock: period in clk cycles, can be paused
    int tick_p   = 8;
    bit bclk_run = 1'b1;
    int bclk_ph  = 0;

    // Transaction-level model
    logic [7:0] exp_q[$];
    int         exp_framing = 0;
    int         exp_overrun = 0;
    int         exp_parity  = 0;
    bit         pending     = 1'b0;

    // Monitor bookkeeping
    int         n_rx = 0;
    int         n_fe = 0;
    int         n_oe = 0;
    int         n_pe = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] held    = 8'h00;
    logic [7:0] exp_b;
    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;

    uart_rx_x8 dut (
        .clk         (clk),
        .reset       (reset),
        .bclk_x8     (bclk_x8),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Square wave of tick_p clk cycles, low for the first half
    initial begin
        bclk_x8 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bclk_run) begin
                bclk_ph = (bclk_ph + 1) % tick_p;
                bclk_x8 = (bclk_ph >= tick_p / 2);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setReady(input bit v);
        rx_ready = v;
        if (v) pending = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        rxd   = 1'b1;
        exp_q.delete();
        exp_framing = 0;
        exp_overrun = 0;
        exp_parity  = 0;
        pending     = 1'b0;
        waitClk(3);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
    endtask

    // Drive one frame. abort_after>0 stops after that many bits (no model
    // update); freeze_bit>=0 pauses bclk_x8 in the middle of that bit and
    // stretches the bit by the same amount.
    task automatic applyStimulus(input logic [7:0] data, input bit bad_stop,
                                 input bit bad_par, input int abort_after,
                                 input int freeze_bit, input int gap_bits);
        logic [15:0] fr;
        int          nb;
        int          bit_clk;
        bit_clk = tick_p * OS;
        fr = '0;
        nb = 0;
        fr[nb] = 1'b0;
        nb++;
        for (int i = 0; i < DB; i++) begin
            fr[nb] = data[i];
            nb++;
        end
`ifdef UART_RX_PARITY_EN
        fr[nb] = (^data) ^ PAR_ODD ^ bad_par;
        nb++;
`endif
        fr[nb] = !bad_stop;
        nb++;

        if (abort_after == 0) begin
            if (bad_stop) begin
                exp_framing++;
            end else begin
                if (pending && !rx_ready) begin
                    exp_overrun++;
                end else begin
                    exp_q.push_back(data);
                    pending = !rx_ready;
                end
`ifdef UART_RX_PARITY_EN
                if (bad_par) exp_parity++;
`endif
            end
        end

        for (int i = 0; i < nb; i++) begin
            if (abort_after > 0 && i == abort_after) begin
                rxd = 1'b1;
                return;
            end
            rxd = fr[i];
            if (i == freeze_bit) begin
                waitClk(bit_clk / 2);
                bclk_run = 1'b0;
                waitClk(2);
                checkOutput("busy_frozen", 32'(busy), 32'd1);
                waitClk(FREEZE_CLK - 2);
                bclk_run = 1'b1;
                waitClk(bit_clk - bit_clk / 2);
            end else begin
                waitClk(bit_clk);
            end
        end
        if (bad_stop) begin
            waitClk(3 * bit_clk);
        end
        rxd = 1'b1;
        waitClk(gap_bits * bit_clk);

        checkOutput("bytes_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("framing_drained", 32'(exp_framing), 32'd0);
        checkOutput("overrun_drained", 32'(exp_overrun), 32'd0);
        checkOutput("parity_drained", 32'(exp_parity), 32'd0);
    endtask

    task automatic glitchPulse(input int len);
        rxd = 1'b0;
        waitClk(len);
        rxd = 1'b1;
        waitClk(2 * tick_p * OS);
        checkOutput("glitch_busy", 32'(busy), 32'd0);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (rx_valid) begin
                if (!prev_valid || prev_ready) begin
                    n_rx++;
                    last_rx = rx_data;
                    held    = rx_data;
                    checkOutput("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        checkOutput("rx_data", 32'(rx_data), 32'(exp_b));
                    end
                end else begin
                    checkOutput("rx_data_stable", 32'(rx_data), 32'(held));
                end
            end
            if (framing_err) begin
                n_fe++;
                checkOutput("framing_expected", 32'(exp_framing > 0), 32'd1);
                if (exp_framing > 0) exp_framing--;
            end
            if (overrun_err) begin
                n_oe++;
                checkOutput("overrun_expected", 32'(exp_overrun > 0), 32'd1);
                if (exp_overrun > 0) exp_overrun--;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                n_pe++;
                checkOutput("parity_expected", 32'(exp_parity > 0), 32'd1);
                if (exp_parity > 0) exp_parity--;
            end
`endif
            prev_valid = rx_valid;
            prev_ready = rx_ready;
        end
    end

    initial begin
        #3_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int         base_rx;
        int         base_fe;
        int         base_oe;
        int         r;
        logic [7:0] d;

        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        waitClk(4);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_busy0", 32'(busy), 32'd0);
        checkOutput("reset_framing", 32'(framing_err), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_err), 32'd0);
        reset = 1'b0;
        waitClk(4);

        // 0xA5 at the real 115200 tick rate
        tick_p = tick_period(BAUD_115200);
        waitClk(2 * tick_p);
        applyStimulus(8'hA5, 1'b0, 1'b0, 0, -1, 2);
        checkOutput("a5_count", 32'(n_rx), 32'd1);
        checkOutput("a5_data", 32'(last_rx), 32'hA5);
        checkOutput("a5_no_fe", 32'(n_fe), 32'd0);
        checkOutput("a5_busy_low", 32'(busy), 32'd0);

        // 40-clk glitch on the idle line
        glitchPulse(40);
        checkOutput("glitch_no_byte", 32'(n_rx), 32'd1);
        checkOutput("glitch_no_fe", 32'(n_fe), 32'd0);

        // Faster oversampling clock for the rest of the run
        tick_p = 8;
        waitClk(4 * tick_p * OS);

        // Bad stop bit then a held-low line, then a good frame
        base_rx = n_rx;
        applyStimulus(8'h3C, 1'b1, 1'b0, 0, -1, 2);
        checkOutput("break_one_fe", 32'(n_fe), 32'd1);
        checkOutput("break_no_byte", 32'(n_rx - base_rx), 32'd0);
        applyStimulus(8'h81, 1'b0, 1'b0, 0, -1, 2);
        checkOutput("after_break_data", 32'(last_rx), 32'h81);

        // Overrun with the consumer stalled
        base_oe = n_oe;
        setReady(1'b0);
        applyStimulus(8'h11, 1'b0, 1'b0, 0, -1, 1);
        applyStimulus(8'h22, 1'b0, 1'b0, 0, -1, 1);
        checkOutput("overrun_held_data", 32'(rx_data), 32'h11);
        checkOutput("overrun_valid", 32'(rx_valid), 32'd1);
        checkOutput("overrun_count", 32'(n_oe - base_oe), 32'd1);
        setReady(1'b1);
        waitClk(2);
        checkOutput("ready_clears_valid", 32'(rx_valid), 32'd0);

        // Reset in the middle of the data bits of 0xFF
        base_rx = n_rx;
        applyStimulus(8'hFF, 1'b0, 1'b0, 5, -1, 0);
        doReset();
        waitClk(2 * tick_p * OS);
        applyStimulus(8'h5A, 1'b0, 1'b0, 0, -1, 2);
        checkOutput("post_reset_count", 32'(n_rx - base_rx), 32'd1);
        checkOutput("post_reset_data", 32'(last_rx), 32'h5A);

        // bclk_x8 paused mid-frame
        applyStimulus(8'h96, 1'b0, 1'b0, 0, 4, 2);
        checkOutput("freeze_data", 32'(last_rx), 32'h96);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: correct parity bit is 1
        base_fe = n_pe;
        applyStimulus(8'h07, 1'b0, 1'b1, 0, -1, 2);
        checkOutput("par_bad_data", 32'(last_rx), 32'h07);
        checkOutput("par_bad_pulse", 32'(n_pe - base_fe), 32'd1);
        applyStimulus(8'h07, 1'b0, 1'b0, 0, -1, 2);
        checkOutput("par_good_pulse", 32'(n_pe - base_fe), 32'd1);
`endif

        // Randomised frames, errors, glitches and consumer stalls
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitchPulse(int'($urandom_range(1, 2 * tick_p)));
            end else begin
                if ($urandom_range(0, 2) == 0) setReady(1'($urandom_range(0, 1)));
                d = 8'($urandom);
                applyStimulus(d, (r == 1), ($urandom_range(0, 2) == 0), 0, -1,
                              int'($urandom_range(1, 3)));
            end
        end
        setReady(1'b1);
        waitClk(4);
        checkOutput("final_valid", 32'(rx_valid), 32'd0);
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
